li_ram_burst_reader: RTL
========================

// Module: li_ram_burst_reader
// PURPOSE
//  Read-side master for li_ram. Accepts one burst command (base address, length).
//  Issues sequential read requests on li_ram's rd_req channel.
//  Collects rd_resp beats into an internal FIFO.
//  Streams the beats out on a valid/ready port, marking the final beat with last.
//  Credit tracking means li_ram responses are never dropped, whatever the output backpressure.
// PARAMETERS
//  ADDR_WIDTH  8   li_ram address width; addresses wrap modulo 2**ADDR_WIDTH
//  DATA_WIDTH  32  li_ram data width
//  FIFO_DEPTH  4   response FIFO entries; power of 2, >=2; also the max requests in flight
// PORTS
//  clk                clk  in   1             clock
//  rst                rst  in   1             reset, synchronous, active-high
//  cmd_addr_in             in   ADDR_WIDTH    burst base address
//  cmd_len_in              in   ADDR_WIDTH+1  beat count, 0..2**ADDR_WIDTH
//  cmd_valid_in            in   1             command valid
//  cmd_ready_out           out  1             command accepted when valid&ready
//  rd_req_addr_out         out  ADDR_WIDTH    to li_ram rd_req_addr_in
//  rd_req_valid_out        out  1             to li_ram rd_req_valid_in
//  rd_req_ready_in         in   1             from li_ram rd_req_ready_out
//  rd_resp_data_in         in   DATA_WIDTH    from li_ram rd_resp_data_out
//  rd_resp_valid_in        in   1             from li_ram rd_resp_valid_out
//  rd_resp_ready_out       out  1             to li_ram rd_resp_ready_in
//  out_data_out            out  DATA_WIDTH    streamed beat
//  out_last_out            out  1             final beat of the burst
//  out_valid_out           out  1             beat valid
//  out_ready_in            in   1             consumer ready
//  busy_out                out  1             high whenever the FSM is not IDLE
// BEHAVIOUR
//  Reset values (the cycle after rst): FSM=IDLE, FIFO empty, all counters 0.
//    All outputs 0 except cmd_ready_out=1 and rd_resp_ready_out=1.
//  Reset mid-burst: flush everything. Responses for requests issued before reset are discarded.
//  FSM state IDLE: cmd_ready_out=1.
//    cmd fire with len>0: latch addr/len, go to ISSUE.
//    cmd fire with len==0: consume the command, stay IDLE, no requests issued.
//  FSM state ISSUE: rd_req_valid_out = (outstanding + fifo_count) < FIFO_DEPTH.
//    On req fire (valid&ready): addr+1 (wraps 2**ADDR_WIDTH-1 -> 0), reqs_left-1, outstanding+1.
//    Once the last request fires, go to DRAIN.
//  FSM state DRAIN: no requests; wait until the last beat has been popped.
//  Return to IDLE: in the same cycle the last beat pops (out fire with out_last_out=1).
//    From either ISSUE or DRAIN; cmd_ready_out=1 from the next cycle.
//  Response handling: rd_resp_ready_out is held at 1.
//    A resp fire while outstanding>0 pushes data into the FIFO and decrements outstanding.
//    A resp fire while outstanding==0 is dropped.
//  Outstanding counter: req fire and resp fire in the same cycle leave it unchanged.
//  Overflow guarantee: the credit rule makes FIFO overflow impossible.
//    Assert outstanding+fifo_count <= FIFO_DEPTH.
//  FIFO: show-ahead. out_valid_out = !empty. Push and pop in the same cycle are both allowed.
//    That includes push while full, provided a pop happens in the same cycle.
//  Latency: a response accepted in cycle N is visible on out_* in cycle N+1.
//  out_last_out: asserted on the head beat when beats_left==1.
//    beats_left is loaded with len and decrements on each out fire.
//  Output stability: out_data_out/out_last_out hold stable while out_valid_out & !out_ready_in.
// CONFIGURATION
//  LI_RAM_BURST_READER_SUM_EN defined: adds two ports.
//    sum_out       out  DATA_WIDTH  sum of all beats output in the burst, modulo 2**DATA_WIDTH
//    sum_valid_out out  1           one-cycle pulse on the cycle the last beat fires
//  Sum accumulator: cleared on cmd accept and on rst.
//    sum_out holds its value until the next command is accepted.
//  With SUM_EN, a len==0 command pulses sum_valid_out with sum_out=0 one cycle after accept.
//  Macro undefined: neither port exists and there is no accumulator logic.
// TESTING  (li_ram preloaded mem[i]=1000+i, FIFO_DEPTH=4, out_ready_in=1 unless stated)
//  1 Basic burst.
//    Stimulus: cmd addr=0 len=4.
//    Response: out 1000,1001,1002,1003; last only on 1003; busy_out falls the cycle after.
//  2 Address wrap.
//    Stimulus: cmd addr=254 len=4.
//    Response: out 1254,1255,1000,1001; rd_req_addr_out sequence 254,255,0,1.
//  3 Backpressure.
//    Stimulus: len=16, out_ready_in=0 for 30 cycles, then 1.
//    Response: exactly 4 req fires before release; all 16 beats in order, none lost.
//  4 Zero length.
//    Stimulus: cmd len=0.
//    Response: one-cycle accept, no rd_req_valid_out, busy_out stays 0.
//  5 Reset mid-burst.
//    Stimulus: rst high after 2 beats of a len=8 burst; then cmd addr=10 len=2.
//    Response: after rst, outputs at reset values; then out 1010,1011 only.
//  6 SUM_EN.
//    Stimulus: cmd addr=0 len=4.
//    Response: sum_out=4006, with sum_valid_out pulsing alongside beat 1003.

Source files
------------

// File: rtl/li_ram_burst_reader.sv
// li_ram_burst_reader: read-side burst master for li_ram.
// Takes one (base, length) command, issues sequential rd_req beats, buffers
// rd_resp beats in a show-ahead FIFO and streams them out with a last marker.
// A request is only issued when the FIFO has room for its response, so
// li_ram responses are never dropped, whatever the output backpressure.
// Optional feature: define LI_RAM_BURST_READER_SUM_EN to add a per-burst
// data sum (sum_out / sum_valid_out).
module li_ram_burst_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
    input  logic [ADDR_WIDTH:0]   cmd_len_in,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    output logic [ADDR_WIDTH-1:0] rd_req_addr_out,
    output logic                  rd_req_valid_out,
    input  logic                  rd_req_ready_in,
    input  logic [DATA_WIDTH-1:0] rd_resp_data_in,
    input  logic                  rd_resp_valid_in,
    output logic                  rd_resp_ready_out,
    output logic [DATA_WIDTH-1:0] out_data_out,
    output logic                  out_last_out,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic                  busy_out
`ifdef LI_RAM_BURST_READER_SUM_EN
    ,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic                  sum_valid_out
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      reqs_left_q;
    logic [LEN_W-1:0]      beats_left_q;
    logic [CNT_W-1:0]      outstanding_q;
    logic [CNT_W-1:0]      fifo_count_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [CNT_W:0] credit_sum;
    logic           credit_ok;
    logic           cmd_fire;
    logic           req_fire;
    logic           resp_fire;
    logic           push;
    logic           pop;
    logic           last_pop;

    // Requests in flight plus buffered beats can never exceed the FIFO size.
    assign credit_sum = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign credit_ok  = credit_sum < (CNT_W+1)'(FIFO_DEPTH);

    assign rd_resp_ready_out = 1'b1;
    assign rd_req_addr_out   = addr_q;

    assign cmd_fire  = cmd_valid_in & cmd_ready_out;
    assign req_fire  = rd_req_valid_out & rd_req_ready_in;
    assign resp_fire = rd_resp_valid_in & rd_resp_ready_out;
    // Responses with no matching request (stale after a reset) are dropped.
    assign push      = resp_fire && (outstanding_q != '0);
    assign pop       = out_valid_out & out_ready_in;
    assign last_pop  = pop & out_last_out;

    assign out_valid_out = (fifo_count_q != '0);
    assign out_data_out  = out_valid_out ? fifo_mem[rd_ptr_q] : '0;
    assign out_last_out  = out_valid_out && (beats_left_q == LEN_W'(1));

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and control outputs
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d          = state_q;
        cmd_ready_out    = 1'b0;
        rd_req_valid_out = 1'b0;
        busy_out         = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_ready_out = 1'b1;
                busy_out      = 1'b0;
                if (cmd_valid_in && (cmd_len_in != '0)) state_d = ISSUE;
            end
            ISSUE: begin
                rd_req_valid_out = credit_ok;
                if (last_pop)
                    state_d = IDLE;
                else if (credit_ok && rd_req_ready_in && (reqs_left_q == LEN_W'(1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (last_pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request address and remaining-request counter
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            reqs_left_q <= '0;
        end else if (cmd_fire) begin
            addr_q      <= cmd_addr_in;
            reqs_left_q <= cmd_len_in;
        end else if (req_fire) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            reqs_left_q <= reqs_left_q - LEN_W'(1);
        end
    end

    // Remaining beats on the output side; drives the last marker
    always_ff @(posedge clk) begin
        if (rst)           beats_left_q <= '0;
        else if (cmd_fire) beats_left_q <= cmd_len_in;
        else if (pop)      beats_left_q <= beats_left_q - LEN_W'(1);
    end

    // Requests issued whose response has not yet arrived
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            case ({req_fire, push})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide, even when full
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; the occupancy count
        // alone decides validity, and unreset storage maps onto plain RAM.
        if (push) fifo_mem[wr_ptr_q] <= rd_resp_data_in;
    end

`ifdef LI_RAM_BURST_READER_SUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  zero_len_pulse_q;

    // Burst sum accumulator and the delayed pulse for zero-length commands
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q            <= '0;
            zero_len_pulse_q <= 1'b0;
        end else begin
            zero_len_pulse_q <= cmd_fire && (cmd_len_in == '0);
            if (cmd_fire)  sum_q <= '0;
            else if (pop)  sum_q <= sum_q + out_data_out;
        end
    end

    // The final beat is folded in combinationally so the sum is complete on its pulse.
    assign sum_out       = last_pop ? (sum_q + out_data_out) : sum_q;
    assign sum_valid_out = last_pop | zero_len_pulse_q;
`endif

    // Credit rule keeps the FIFO from ever overflowing.
    a_credit_bound : assert property (@(posedge clk) disable iff (rst)
        credit_sum <= (CNT_W+1)'(FIFO_DEPTH));

endmodule
